// File: rtl/ei_axi4_reg_slice.sv
// AXI4 register slice: every channel (AW, W, B, AR, R) is cut by a two-entry skid buffer.
// Define EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN to throttle AW/AR acceptance at MAX_OUTSTANDING.

module ei_axi4_reg_slice_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           in_hs, out_hs;

    assign in_hs  = in_valid & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_hs && !out_hs) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (!in_hs && out_hs) begin
                    state_d = EMPTY;
                end else if (in_hs && out_hs) begin
                    main_d  = in_data;
                end
            end
            TWO: begin
                if (out_hs) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake flags are registered from the next state so no combinational path crosses the slice.
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
endmodule

module ei_axi4_reg_slice #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);
    localparam int AX_W = ADDR_WIDTH + 13;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8 + 1;
    localparam int R_W  = DATA_WIDTH + 3;

    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be 8*2^n");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be in 1..255");
    end

    logic aw_block, ar_block;
    logic aw_buf_ready, ar_buf_ready;

    assign s_awready = aw_buf_ready & ~aw_block;
    assign s_arready = ar_buf_ready & ~ar_block;

`ifdef EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             aw_hs, b_hs, ar_hs, rlast_hs;

    assign aw_hs    = s_awvalid & s_awready;
    assign b_hs     = s_bvalid & s_bready;
    assign ar_hs    = s_arvalid & s_arready;
    assign rlast_hs = s_rvalid & s_rready & s_rlast;
    assign aw_block = (wr_cnt_q == CNT_MAX);
    assign ar_block = (rd_cnt_q == CNT_MAX);

    // Increment is blocked at the limit and decrement at zero, so neither counter can wrap.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (aw_hs && !b_hs)
            wr_cnt_d = wr_cnt_q + 1'b1;
        else if (!aw_hs && b_hs && wr_cnt_q != '0)
            wr_cnt_d = wr_cnt_q - 1'b1;
        if (ar_hs && !rlast_hs)
            rd_cnt_d = rd_cnt_q + 1'b1;
        else if (!ar_hs && rlast_hs && rd_cnt_q != '0)
            rd_cnt_d = rd_cnt_q - 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
`else
    assign aw_block = 1'b0;
    assign ar_block = 1'b0;
`endif

    ei_axi4_reg_slice_skid #(.W(AX_W)) u_aw (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (s_awvalid & ~aw_block),
        .in_data   ({s_awaddr, s_awlen, s_awsize, s_awburst}),
        .in_ready  (aw_buf_ready),
        .out_valid (m_awvalid),
        .out_data  ({m_awaddr, m_awlen, m_awsize, m_awburst}),
        .out_ready (m_awready)
    );

    ei_axi4_reg_slice_skid #(.W(W_W)) u_w (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (s_wvalid),
        .in_data   ({s_wdata, s_wstrb, s_wlast}),
        .in_ready  (s_wready),
        .out_valid (m_wvalid),
        .out_data  ({m_wdata, m_wstrb, m_wlast}),
        .out_ready (m_wready)
    );

    ei_axi4_reg_slice_skid #(.W(2)) u_b (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (m_bvalid),
        .in_data   (m_bresp),
        .in_ready  (m_bready),
        .out_valid (s_bvalid),
        .out_data  (s_bresp),
        .out_ready (s_bready)
    );

    ei_axi4_reg_slice_skid #(.W(AX_W)) u_ar (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (s_arvalid & ~ar_block),
        .in_data   ({s_araddr, s_arlen, s_arsize, s_arburst}),
        .in_ready  (ar_buf_ready),
        .out_valid (m_arvalid),
        .out_data  ({m_araddr, m_arlen, m_arsize, m_arburst}),
        .out_ready (m_arready)
    );

    ei_axi4_reg_slice_skid #(.W(R_W)) u_r (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_valid  (m_rvalid),
        .in_data   ({m_rdata, m_rresp, m_rlast}),
        .in_ready  (m_rready),
        .out_valid (s_rvalid),
        .out_data  ({s_rdata, s_rresp, s_rlast}),
        .out_ready (s_rready)
    );
endmodule

// File: tb/tb_ei_axi4_reg_slice.sv
// Bench for ei_axi4_reg_slice: per-channel two-deep FIFO model compared every cycle plus directed literal checks.

module tb_ei_axi4_reg_slice;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN
    localparam int MAXO = 2;
`else
    localparam int MAXO = 4;
`endif

    logic aclk, aresetn;
    logic [AW-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [7:0] s_awlen, m_awlen, s_arlen, m_arlen;
    logic [2:0] s_awsize, m_awsize, s_arsize, m_arsize;
    logic [1:0] s_awburst, m_awburst, s_arburst, m_arburst;
    logic s_awvalid, s_awready, m_awvalid, m_awready;
    logic s_arvalid, s_arready, m_arvalid, m_arready;
    logic [DW-1:0] s_wdata, m_wdata, m_rdata, s_rdata;
    logic [DW/8-1:0] s_wstrb, m_wstrb;
    logic s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
    logic [1:0] m_bresp, s_bresp, m_rresp, s_rresp;
    logic m_bvalid, m_bready, s_bvalid, s_bready;
    logic m_rlast, s_rlast, m_rvalid, m_rready, s_rvalid, s_rready;

    int checks = 0;
    int errors = 0;

    ei_axi4_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Channel views: 0=AW 1=W 2=B 3=AR 4=R (producer side -> consumer side)
    string       cn[5] = '{"aw", "w", "b", "ar", "r"};
    logic        in_v[5];
    logic [63:0] in_d[5];
    logic        o_r[5];
    logic        dv[5];
    logic [63:0] dd[5];
    logic        dr[5];

    always_comb begin
        in_v[0] = s_awvalid; in_d[0] = 64'({s_awaddr, s_awlen, s_awsize, s_awburst}); o_r[0] = m_awready;
        dv[0]   = m_awvalid; dd[0]   = 64'({m_awaddr, m_awlen, m_awsize, m_awburst}); dr[0] = s_awready;
        in_v[1] = s_wvalid;  in_d[1] = 64'({s_wdata, s_wstrb, s_wlast}); o_r[1] = m_wready;
        dv[1]   = m_wvalid;  dd[1]   = 64'({m_wdata, m_wstrb, m_wlast}); dr[1] = s_wready;
        in_v[2] = m_bvalid;  in_d[2] = 64'(m_bresp); o_r[2] = s_bready;
        dv[2]   = s_bvalid;  dd[2]   = 64'(s_bresp); dr[2] = m_bready;
        in_v[3] = s_arvalid; in_d[3] = 64'({s_araddr, s_arlen, s_arsize, s_arburst}); o_r[3] = m_arready;
        dv[3]   = m_arvalid; dd[3]   = 64'({m_araddr, m_arlen, m_arsize, m_arburst}); dr[3] = s_arready;
        in_v[4] = m_rvalid;  in_d[4] = 64'({m_rdata, m_rresp, m_rlast}); o_r[4] = s_rready;
        dv[4]   = s_rvalid;  dd[4]   = 64'({s_rdata, s_rresp, s_rlast}); dr[4] = m_rready;
    end

    // Model: each channel is a FIFO of at most two beats; ready means "room left", seen one edge late after reset.
    logic [63:0] md[5][2];
    int          mc[5];
    bit          alive;
    int          wr_m, rd_m;

    function automatic bit m_ready(input int c);
        bit r;
        r = alive && (mc[c] < 2);
`ifdef EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN
        if (c == 0 && wr_m >= MAXO) r = 1'b0;
        if (c == 3 && rd_m >= MAXO) r = 1'b0;
`endif
        return r;
    endfunction

    initial begin
        bit ih[5];
        bit oh[5];
        bit rl;
        for (int c = 0; c < 5; c++) mc[c] = 0;
        alive = 1'b0; wr_m = 0; rd_m = 0;
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                for (int c = 0; c < 5; c++) mc[c] = 0;
                alive = 1'b0; wr_m = 0; rd_m = 0;
            end else begin
                for (int c = 0; c < 5; c++) begin
                    ih[c] = in_v[c] && m_ready(c);
                    oh[c] = (mc[c] > 0) && o_r[c];
                end
                rl = oh[4] && md[4][0][0];
`ifdef EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN
                if (ih[0] && !oh[2]) wr_m++;
                else if (!ih[0] && oh[2] && wr_m > 0) wr_m--;
                if (ih[3] && !rl) rd_m++;
                else if (!ih[3] && rl && rd_m > 0) rd_m--;
`endif
                for (int c = 0; c < 5; c++) begin
                    if (oh[c]) begin
                        md[c][0] = md[c][1];
                        mc[c]--;
                    end
                    if (ih[c]) begin
                        md[c][mc[c]] = in_d[c];
                        mc[c]++;
                    end
                end
                alive = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("%s_valid", cn[c]), 64'(dv[c]), 64'(mc[c] > 0));
                chk($sformatf("%s_ready", cn[c]), 64'(dr[c]), 64'(m_ready(c)));
                if (mc[c] > 0) chk($sformatf("%s_payload", cn[c]), dd[c], md[c][0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [31:0] rec[16];
        logic        rec_l[16];
        int n, idx;
        bit hs;

        aresetn = 1'b0;
        s_awaddr = 32'hDEAD0000; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = 2'd1; s_awvalid = 1'b1;
        s_araddr = 32'hBEEF0000; s_arlen = 8'd1; s_arsize = 3'd2; s_arburst = 2'd1; s_arvalid = 1'b1;
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
        m_bresp = 2'b10; m_bvalid = 1'b1;
        m_rdata = 32'hCAFEF00D; m_rresp = 2'b01; m_rlast = 1'b1; m_rvalid = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; s_bready = 1'b1; m_arready = 1'b1; s_rready = 1'b1;

        // Reset held with every producer valid asserted
        repeat (3) step();
        chk("rst_readies", 64'({s_awready, s_wready, m_bready, s_arready, m_rready}), 64'h0);
        chk("rst_valids", 64'({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}), 64'h0);
        chk("rst_payload", 64'({m_awaddr, m_wdata}), 64'h0);
        chk("rst_rdata", 64'(s_rdata), 64'h0);
        aresetn = 1'b1;
        step();
        chk("rel_readies", 64'({s_awready, s_wready, m_bready, s_arready, m_rready}), 64'h1F);
        chk("rel_valids", 64'({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}), 64'h0);
        s_awvalid = 1'b0; s_arvalid = 1'b0; s_wvalid = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        m_rlast = 1'b0; s_wlast = 1'b0;
        step();

        // 16-beat write burst streaming
        s_awaddr = 32'h1000; s_awlen = 8'd15; s_awsize = 3'd2; s_awburst = 2'd1; s_awvalid = 1'b1;
        idx = 0; n = 0;
        for (int cyc = 0; cyc < 60 && n < 16; cyc++) begin
            s_wvalid = (idx < 16); s_wdata = 32'(idx); s_wstrb = 4'hF; s_wlast = (idx == 15);
            hs = s_wvalid && s_wready;
            if (s_awvalid && s_awready) begin
                step();
                s_awvalid = 1'b0;
            end else begin
                step();
            end
            if (hs) idx++;
            if (m_wvalid) begin
                rec[n] = m_wdata; rec_l[n] = m_wlast; n++;
            end
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        chk("w_beats", 64'(n), 64'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("w_data%0d", k), 64'(rec[k]), 64'(k));
            chk($sformatf("w_last%0d", k), 64'(rec_l[k]), 64'(k == 15));
        end
        step();

        // Back-to-back AR: in and out handshakes share edges
        idx = 0; n = 0;
        for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
            s_arvalid = (idx < 3); s_araddr = 32'((idx + 1) * 256); s_arlen = 8'd0;
`ifdef EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN
            m_rvalid = 1'b1; m_rdata = 32'hEE; m_rresp = 2'b00; m_rlast = 1'b1;
`else
            if (idx < 3) chk("ar_ready_held", 64'(s_arready), 64'd1);
`endif
            if (m_arvalid && m_arready) begin
                rec[n] = m_araddr; n++;
            end
            hs = s_arvalid && s_arready;
            step();
            if (hs) idx++;
        end
        s_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("ar_count", 64'(n), 64'd3);
        chk("ar_seq0", 64'(rec[0]), 64'h100);
        chk("ar_seq1", 64'(rec[1]), 64'h200);
        chk("ar_seq2", 64'(rec[2]), 64'h300);
        repeat (3) step();

        // R stream with a five-cycle consumer stall
        idx = 0; n = 0;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            s_rready = !(cyc >= 2 && cyc <= 6);
            m_rvalid = (idx < 8); m_rdata = 32'hA0 + 32'(idx); m_rresp = 2'(idx); m_rlast = (idx == 7);
            if (cyc == 2) chk("bp_ready_before", 64'(m_rready), 64'd1);
            if (cyc == 3) begin
                chk("bp_ready_dropped", 64'(m_rready), 64'd0);
                chk("bp_head", 64'(s_rdata), 64'hA1);
                chk("bp_valid", 64'(s_rvalid), 64'd1);
            end
            if (s_rvalid && s_rready) begin
                rec[n] = s_rdata; n++;
            end
            hs = m_rvalid && m_rready;
            step();
            if (hs) idx++;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1;
        chk("r_count", 64'(n), 64'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("r_data%0d", k), 64'(rec[k]), 64'(32'hA0 + k));
        step();

`ifdef EI_AXI4_REG_SLICE_OUTSTANDING_LIMIT_EN
        // Outstanding limit of two writes
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        m_awready = 1'b1; s_bready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            s_awvalid = 1'b1; s_awaddr = 32'h2000 + 32'(idx); s_awlen = 8'd0;
            hs = s_awvalid && s_awready;
            step();
            if (hs) idx++;
        end
        chk("lim_accepted", 64'(idx), 64'd2);
        chk("lim_awready_low", 64'(s_awready), 64'd0);
        m_bvalid = 1'b1; m_bresp = 2'b01;
        step();
        m_bvalid = 1'b0;
        chk("lim_awready_still_low", 64'(s_awready), 64'd0);
        step();
        chk("lim_awready_back", 64'(s_awready), 64'd1);
        step();
        s_awvalid = 1'b0;
        chk("lim_third_addr", 64'(m_awaddr), 64'h2002);
        step();
`endif

        // Asynchronous reset with two W beats buffered
        m_wready = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'h55; s_wlast = 1'b0;
        step();
        s_wdata = 32'h66;
        step();
        s_wvalid = 1'b0;
        chk("mid_full_valid", 64'(m_wvalid), 64'd1);
        chk("mid_full_ready", 64'(s_wready), 64'd0);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_wvalid), 64'd0);
        chk("mid_rst_ready", 64'(s_wready), 64'd0);
        #2 aresetn = 1'b1;
        step();
        chk("mid_rel_ready", 64'(s_wready), 64'd1);
        chk("mid_rel_valid", 64'(m_wvalid), 64'd0);
        m_wready = 1'b1;
        s_wvalid = 1'b1; s_wdata = 32'h77; s_wlast = 1'b1;
        step();
        s_wvalid = 1'b0; s_wlast = 1'b0;
        chk("mid_first_valid", 64'(m_wvalid), 64'd1);
        chk("mid_first_data", 64'(m_wdata), 64'h77);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
